// File: rtl/flow_lights_monitor_pkg.sv
// flow_lights_monitor_pkg: shared defaults, tracker state encoding and step counter width.
package flow_lights_monitor_pkg;
    localparam int LED_W_DEF   = 16;
    localparam int MAX_RUN_DEF = 7;
    localparam int STEP_W      = 8;
    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
endpackage

// File: rtl/flow_lights_monitor_decode.sv
// flow_run_decode: finds the single circular run of ones in an LED vector (legal flag, length, start index).
module flow_run_decode
    import flow_lights_monitor_pkg::*;
#(
    parameter int LED_W   = LED_W_DEF,
    parameter int MAX_RUN = MAX_RUN_DEF,
    localparam int POS_W  = $clog2(LED_W),
    localparam int RUN_W  = $clog2(MAX_RUN + 1)
) (
    input  logic [LED_W-1:0] i_led,
    output logic             o_legal,
    output logic [RUN_W-1:0] o_count,
    output logic [POS_W-1:0] o_pos
);
    localparam int SUM_W = $clog2(LED_W + 1);
    logic [SUM_W-1:0] w_ones;
    logic [SUM_W-1:0] w_starts;
    logic [POS_W-1:0] w_start;
    // A run start is a lit LED whose circular predecessor is dark; zero and all-ones have none.
    always_comb begin
        w_ones   = '0;
        w_starts = '0;
        w_start  = '0;
        for (int i = 0; i < LED_W; i++) begin
            w_ones = w_ones + SUM_W'(i_led[i]);
            if (i_led[i] && !i_led[(i + LED_W - 1) % LED_W]) begin
                w_starts = w_starts + SUM_W'(1);
                w_start  = POS_W'(i);
            end
        end
    end
    assign o_legal = (w_starts == SUM_W'(1)) && (int'(w_ones) <= MAX_RUN);
    assign o_count = o_legal ? RUN_W'(w_ones) : '0;
    assign o_pos   = o_legal ? w_start : '0;
endmodule

// File: rtl/flow_lights_monitor.sv
// flow_lights_monitor: checks a flow-lights LED pattern each cycle and tracks single-position steps,
// resizes and protocol violations against a stored baseline run.
module flow_lights_monitor
    import flow_lights_monitor_pkg::*;
#(
    parameter int LED_W   = LED_W_DEF,
    parameter int MAX_RUN = MAX_RUN_DEF,
    localparam int POS_W  = $clog2(LED_W),
    localparam int RUN_W  = $clog2(MAX_RUN + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LED_W-1:0]  io_led,
    input  logic              io_clear,
    output logic              io_valid,
    output logic [RUN_W-1:0]  io_ledCount,
    output logic [POS_W-1:0]  io_pos,
    output logic              io_step,
    output logic              io_resize,
    output logic [STEP_W-1:0] io_stepCount,
    output logic              io_error
);
    state_t           r_state;
    logic [RUN_W-1:0] r_base_count;
    logic [POS_W-1:0] r_base_pos;
    logic             w_legal;
    logic             w_zero;
    logic             w_bad;
    logic [RUN_W-1:0] w_count;
    logic [POS_W-1:0] w_pos;
    logic [POS_W-1:0] w_next_pos;

    flow_run_decode #(.LED_W(LED_W), .MAX_RUN(MAX_RUN)) u_decode (
        .i_led  (io_led),
        .o_legal(w_legal),
        .o_count(w_count),
        .o_pos  (w_pos)
    );

    assign w_zero     = io_led == '0;
    assign w_bad      = !w_zero && !w_legal;
    assign w_next_pos = (r_base_pos == POS_W'(LED_W - 1)) ? '0 : r_base_pos + POS_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_base_count <= '0;
            r_base_pos   <= '0;
            io_valid     <= 1'b0;
            io_ledCount  <= '0;
            io_pos       <= '0;
            io_step      <= 1'b0;
            io_resize    <= 1'b0;
            io_stepCount <= '0;
            io_error     <= 1'b0;
        end else begin
            io_valid    <= w_legal;
            io_ledCount <= w_count;
            io_pos      <= w_pos;
            io_step     <= 1'b0;
            io_resize   <= 1'b0;
            if (io_clear)
                io_stepCount <= '0;
            case (r_state)
                IDLE: begin
                    if (w_bad) begin
                        r_state  <= FAULT;
                        io_error <= 1'b1;
                    end else if (w_legal) begin
                        r_state      <= TRACK;
                        r_base_count <= w_count;
                        r_base_pos   <= w_pos;
                    end
                end
                TRACK: begin
                    if (w_bad) begin
                        r_state  <= FAULT;
                        io_error <= 1'b1;
                    end else if (w_zero) begin
                        r_state <= IDLE;
                    end else if (w_count == r_base_count && w_pos == r_base_pos) begin
                        r_state <= TRACK;
                    end else if (w_count == r_base_count && w_pos == w_next_pos) begin
                        io_step    <= 1'b1;
                        r_base_pos <= w_pos;
                        // A coincident clear wins over the increment.
                        if (!io_clear && io_stepCount != '1)
                            io_stepCount <= io_stepCount + STEP_W'(1);
                    end else if (w_pos == r_base_pos) begin
                        io_resize    <= 1'b1;
                        r_base_count <= w_count;
                    end else begin
                        r_state  <= FAULT;
                        io_error <= 1'b1;
                    end
                end
                default: begin
                    if (io_clear) begin
                        r_state  <= IDLE;
                        io_error <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flow_lights_monitor.sv
// tb_flow_lights_monitor: directed and randomized checks of flow_lights_monitor against a rotation-based reference model.
module tb_flow_lights_monitor;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_clear;
    logic [15:0] io_led;
    logic        io_valid;
    logic [2:0]  io_ledCount;
    logic [3:0]  io_pos;
    logic        io_step;
    logic        io_resize;
    logic [7:0]  io_stepCount;
    logic        io_error;

    int checks = 0;
    int errors = 0;
    bit m_base, m_fault;
    int m_len, m_pos, m_cnt;
    bit e_valid, e_step, e_resize;
    int e_len, e_pos;
    int g_len = 3;
    int g_pos = 0;

    always #5 clock = ~clock;

    flow_lights_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .io_led      (io_led),
        .io_clear    (io_clear),
        .io_valid    (io_valid),
        .io_ledCount (io_ledCount),
        .io_pos      (io_pos),
        .io_step     (io_step),
        .io_resize   (io_resize),
        .io_stepCount(io_stepCount),
        .io_error    (io_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] run(input int len, input int pos);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < len; k++) v[(pos + k) % 16] = 1'b1;
        return v;
    endfunction

    // Legal iff some rotation brings the pattern to a block of ones anchored at bit 0.
    task automatic decode(input logic [15:0] v, output bit ok, output int len, output int pos);
        logic [31:0] w;
        ok  = 0;
        pos = 0;
        len = $countones(v);
        if (len == 0 || len > 7) return;
        for (int p = 0; p < 16; p++) begin
            w = {v, v} >> p;
            if (w[15:0] == 16'((1 << len) - 1)) begin
                ok  = 1;
                pos = p;
            end
        end
    endtask

    task automatic model(input logic [15:0] led, input bit clr, input bit rst);
        bit ok;
        int len, pos;
        decode(led, ok, len, pos);
        e_valid  = ok;
        e_len    = ok ? len : 0;
        e_pos    = ok ? pos : 0;
        e_step   = 0;
        e_resize = 0;
        if (rst) begin
            e_valid = 0; e_len = 0; e_pos = 0;
            m_base = 0; m_fault = 0; m_cnt = 0;
            return;
        end
        if (m_fault) begin
            if (clr) m_fault = 0;
        end else if (led != 0 && !ok) begin
            m_fault = 1; m_base = 0;
        end else if (led == 0) begin
            m_base = 0;
        end else if (!m_base) begin
            m_base = 1; m_len = len; m_pos = pos;
        end else if (len == m_len && pos == (m_pos + 1) % 16) begin
            e_step = 1; m_pos = pos;
            if (m_cnt < 255) m_cnt++;
        end else if (pos == m_pos && len != m_len) begin
            e_resize = 1; m_len = len;
        end else if (len != m_len || pos != m_pos) begin
            m_fault = 1; m_base = 0;
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic cyc(input logic [15:0] led, input bit clr = 0, input bit rst = 0);
        io_led   = led;
        io_clear = clr;
        reset    = rst;
        @(posedge clock);
        model(led, clr, rst);
        #1;
        check("valid", io_valid, e_valid);
        check("ledCount", io_ledCount, e_len);
        check("pos", io_pos, e_pos);
        check("step", io_step, e_step);
        check("resize", io_resize, e_resize);
        check("stepCount", io_stepCount, m_cnt);
        check("error", io_error, m_fault);
    endtask

    initial begin
        // Reset outranks a concurrent clear and pattern.
        cyc(16'h0007, 1, 1);
        cyc(16'hFFFF, 1, 1);
        check("rst_valid", io_valid, 0);
        check("rst_error", io_error, 0);

        cyc(16'h0007);
        cyc(16'h000E);
        check("r36_valid", io_valid, 1);
        check("r36_count", io_ledCount, 3);
        check("r36_pos", io_pos, 1);
        check("r36_step", io_step, 1);
        check("r36_stepCount", io_stepCount, 1);

        cyc(16'h0000, 0, 1);
        cyc(16'h8001);
        check("r37_pos_a", io_pos, 15);
        check("r37_count_a", io_ledCount, 2);
        cyc(16'h0003);
        check("r37_pos_b", io_pos, 0);
        check("r37_step", io_step, 1);
        check("r37_error", io_error, 0);

        cyc(16'h0000, 0, 1);
        cyc(16'h0001);
        cyc(16'h0007);
        check("r38_resize", io_resize, 1);
        check("r38_count", io_ledCount, 3);
        check("r38_stepCount", io_stepCount, 0);

        cyc(16'h0000, 0, 1);
        cyc(16'h0003);
        cyc(16'h0030);
        check("r39_error", io_error, 1);
        cyc(16'h0060);
        cyc(16'h00C0);
        check("r39_sticky", io_error, 1);
        check("r39_decode", io_pos, 6);
        cyc(16'h0180, 1);
        check("r39_cleared", io_error, 0);
        cyc(16'h0300);
        check("r39_rebase", io_step, 0);

        cyc(16'h0000, 0, 1);
        cyc(16'h0101);
        check("r40_two_valid", io_valid, 0);
        check("r40_two_error", io_error, 1);
        cyc(16'h0000, 1);
        cyc(16'h00FF);
        check("r40_long_error", io_error, 1);
        cyc(16'h0000, 1);
        cyc(16'h0000);
        check("r40_zero_valid", io_valid, 0);
        check("r40_zero_error", io_error, 0);

        cyc(16'h0000, 0, 1);
        cyc(run(1, 0));
        for (int k = 1; k <= 300; k++) cyc(run(1, k % 16));
        check("r41_sat", io_stepCount, 255);
        cyc(run(1, 301 % 16), 1);
        check("r41_clr_step", io_step, 1);
        check("r41_clr_count", io_stepCount, 0);

        cyc(16'h0000, 0, 1);
        for (int n = 0; n < 2000; n++) begin
            int r;
            logic [15:0] v;
            r = $urandom_range(99);
            if (r < 50) g_pos = (g_pos + 1) % 16;
            else if (r < 60) g_len = $urandom_range(7, 1);
            else if (r < 66) g_pos = $urandom_range(15);
            if (r < 70) v = run(g_len, g_pos);
            else if (r < 78) v = 16'h0000;
            else if (r < 86) v = 16'($urandom);
            else if (r < 93) v = run(g_len, g_pos) | run(1, (g_pos + g_len + 2) % 16);
            else v = run($urandom_range(15, 8), g_pos);
            cyc(v, $urandom_range(99) < 4, $urandom_range(999) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
